// File: rtl/vga_pkg.sv
// Shared constants, attribute layout and colour helpers for the text renderer.
package vga_pkg;

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 30;
    localparam int unsigned CELL_W = 8;
    localparam int unsigned CELL_H = 16;

    localparam int unsigned PTR_W      = 10;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned XSUB_W     = $clog2(CELL_W);
    localparam int unsigned YSUB_W     = $clog2(CELL_H);
    localparam int unsigned ROW_IDX_W  = PTR_W - YSUB_W;
    localparam int unsigned COL_IDX_W  = PTR_W - XSUB_W;
    // Wide enough for the cell index of any x_ptr/y_ptr pair, including blanking.
    localparam int unsigned CELL_IDX_W = 13;

    // Attribute word: [7:0] code, [10:8] fg, [13:11] bg, [14] blink, [15] reserved.
    typedef struct packed {
        logic       rsvd;
        logic       blink;
        logic [2:0] bg;
        logic [2:0] fg;
        logic [7:0] code;
    } attr_t;

    // Expand a 3-bit RGB colour to the RGB332 pin layout.
    function automatic logic [7:0] rgb332(input logic [2:0] c);
        return {{3{c[2]}}, {3{c[1]}}, {2{c[0]}}};
    endfunction

    // row*cols built from shifted partial sums of the constant column count.
    function automatic logic [CELL_IDX_W-1:0] row_base(input logic [ROW_IDX_W-1:0] row,
                                                       input int unsigned cols);
        logic [CELL_IDX_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (cols[i]) begin
                acc = acc + (CELL_IDX_W'(row) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_text_render_if.sv
// CPU-side bus of the text renderer: buffer writes and cursor control.
interface vga_text_render_if;
    import vga_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] cursor_addr;
    logic              cursor_en;

    modport master (output wr_en, wr_addr, wr_data, cursor_addr, cursor_en);
    modport slave  (input  wr_en, wr_addr, wr_data, cursor_addr, cursor_en);
endinterface

// File: rtl/font_rom.sv
// 4096x8 synchronous-read glyph ROM addressed {char, row}; unlisted codes are blank.
module font_rom (
    input  logic        clk,
    input  logic        en,
    input  logic [11:0] addr,
    output logic [7:0]  data
);

    localparam logic [0:15][7:0] GLYPH_A = {
        8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
        8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00
    };
    localparam logic [0:15][7:0] GLYPH_B = {
        8'h00, 8'h00, 8'hFC, 8'h66, 8'h66, 8'h66, 8'h7C, 8'h66,
        8'h66, 8'h66, 8'h66, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Glyph table lookup; CP437 0xDB is the solid block.
    function automatic logic [7:0] lookup(input logic [11:0] a);
        logic [7:0] g;
        g = 8'h00;
        case (a[11:4])
            8'h41:   g = GLYPH_A[a[3:0]];
            8'h42:   g = GLYPH_B[a[3:0]];
            8'hDB:   g = 8'hFF;
            default: g = 8'h00;
        endcase
        return g;
    endfunction

    // Registered read, advancing with the pixel pipeline.
    always_ff @(posedge clk) begin
        if (en) begin
            data <= lookup(addr);
        end
    end

endmodule

// File: rtl/vga_text_render.sv
// 80x30 text-mode renderer: cell lookup, glyph fetch, colour/blink/cursor, sync realignment.
module vga_text_render #(
    parameter int unsigned COLS         = vga_pkg::COLS,
    parameter int unsigned ROWS         = vga_pkg::ROWS,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_en,
    input  logic [vga_pkg::PTR_W-1:0] x_ptr,
    input  logic [vga_pkg::PTR_W-1:0] y_ptr,
    input  logic                     valid_in,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    vga_text_render_if.slave         cpu,
    output logic                     hsync,
    output logic                     vsync,
    output logic [2:0]               VGA_R,
    output logic [2:0]               VGA_G,
    output logic [1:0]               VGA_B
);
    import vga_pkg::*;

    localparam int unsigned DEPTH = COLS * ROWS;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    attr_t                 mem [DEPTH];
    attr_t                 rd_attr;

    logic [CELL_IDX_W-1:0] cell_c;
    logic                  cell_ok_c;
    logic                  wr_ok_c;
    logic                  cur_hit_c;
    logic                  vs_fall_c;

    logic                  s1_valid, s1_hs, s1_vs, s1_cur;
    logic [XSUB_W-1:0]     s1_x;
    logic [YSUB_W-1:0]     s1_y;

    logic [7:0]            glyph;
    logic                  s2_valid, s2_hs, s2_vs, s2_cur, s2_blink;
    logic [XSUB_W-1:0]     s2_x;
    logic [YSUB_W-1:0]     s2_y;
    logic [2:0]            s2_fg, s2_bg;

    logic [FW-1:0]         frame_cnt;
    logic                  phase;

    logic                  on_c;
    logic [2:0]            colour_c;
    logic [7:0]            rgb_c;

    logic                  unused;
    assign unused = rd_attr.rsvd;

    // Cell index, range qualifiers, cursor match and vsync falling-edge detect.
    always_comb begin
        cell_c    = row_base(y_ptr[PTR_W-1:YSUB_W], COLS)
                  + CELL_IDX_W'(x_ptr[PTR_W-1:XSUB_W]);
        cell_ok_c = 32'(cell_c) < DEPTH;
        wr_ok_c   = cpu.wr_en && (32'(cpu.wr_addr) < DEPTH);
        cur_hit_c = cpu.cursor_en && (cell_c == CELL_IDX_W'(cpu.cursor_addr));
        vs_fall_c = s1_vs && !vsync_in;
    end

    // Text buffer: CPU writes any clk, pixel reads on pix_en (old data on collision).
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[AW'(cpu.wr_addr)] <= attr_t'(cpu.wr_data);
        end
        if (pix_en) begin
            rd_attr <= cell_ok_c ? mem[AW'(cell_c)] : '0;
        end
    end

    // S1: sideband capture alongside the buffer read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s1_cur   <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (pix_en) begin
            s1_valid <= valid_in;
            s1_hs    <= hsync_in;
            s1_vs    <= vsync_in;
            s1_cur   <= cur_hit_c;
            s1_x     <= x_ptr[XSUB_W-1:0];
            s1_y     <= y_ptr[YSUB_W-1:0];
        end
    end

    // Blink timer: count frames on vsync falls, toggle phase every BLINK_FRAMES.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (pix_en && vs_fall_c) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    // S2: glyph row fetch.
    font_rom u_font (
        .clk  (clk),
        .en   (pix_en),
        .addr ({rd_attr.code, s1_y}),
        .data (glyph)
    );

    // S2: attributes and delayed sidebands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_hs    <= 1'b1;
            s2_vs    <= 1'b1;
            s2_cur   <= 1'b0;
            s2_blink <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_fg    <= '0;
            s2_bg    <= '0;
        end else if (pix_en) begin
            s2_valid <= s1_valid;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
            s2_cur   <= s1_cur;
            s2_blink <= rd_attr.blink;
            s2_x     <= s1_x;
            s2_y     <= s1_y;
            s2_fg    <= rd_attr.fg;
            s2_bg    <= rd_attr.bg;
        end
    end

    // S3 colour: glyph bit (MSB is leftmost, ~x == 7-x), blink mask, cursor underline, valid mask.
    always_comb begin
        on_c = glyph[~s2_x] && !(s2_blink && !phase);
        if (s2_cur && phase && (s2_y >= YSUB_W'(CELL_H - 2))) begin
            on_c = 1'b1;
        end
        colour_c = on_c ? s2_fg : s2_bg;
        rgb_c    = s2_valid ? rgb332(colour_c) : 8'h00;
    end

    // S3: registered pins, syncs aligned with the pixel data.
    always_ff @(posedge clk) begin
        if (rst) begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_en) begin
            {VGA_R, VGA_G, VGA_B} <= rgb_c;
            hsync <= s2_hs;
            vsync <= s2_vs;
        end
    end

endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render: vector table plus multi-cycle corner sequences.
module tb_vga_text_render;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic [9:0] x_ptr, y_ptr;
    logic       valid_in, hsync_in, vsync_in;
    logic       hsync, vsync;
    logic [2:0] vga_r, vga_g;
    logic [1:0] vga_b;
    logic [7:0] rgb;

    int n_vec = 0;
    int n_err = 0;
    int falls = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       v;
        logic       hs;
        logic [7:0] rgb;
    } vec_t;

    vec_t vt [16];

    vga_text_render_if cpu();

    vga_text_render #(
        .COLS         (80),
        .ROWS         (30),
        .BLINK_FRAMES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (pix_en),
        .x_ptr    (x_ptr),
        .y_ptr    (y_ptr),
        .valid_in (valid_in),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .cpu      (cpu),
        .hsync    (hsync),
        .vsync    (vsync),
        .VGA_R    (vga_r),
        .VGA_G    (vga_g),
        .VGA_B    (vga_b)
    );

    assign rgb = {vga_r, vga_g, vga_b};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One pixel tick (pix_en high for one clk, then three idle clks), optional same-clk write.
    task automatic pix_w(input logic [9:0] x, input logic [9:0] y, input logic v,
                         input logic hs, input logic vs,
                         input logic we, input logic [11:0] wa, input logic [15:0] wd);
        @(negedge clk);
        x_ptr = x; y_ptr = y; valid_in = v; hsync_in = hs; vsync_in = vs;
        cpu.wr_en = we; cpu.wr_addr = wa; cpu.wr_data = wd;
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        cpu.wr_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic v,
                       input logic hs, input logic vs);
        pix_w(x, y, v, hs, vs, 1'b0, 12'd0, 16'h0000);
    endtask

    task automatic idle();
        pix(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic render(input string name, input logic [9:0] x, input logic [9:0] y,
                          input logic [7:0] exp);
        pix(x, y, 1'b1, 1'b1, 1'b1);
        idle();
        idle();
        check(name, rgb, exp);
    endtask

    task automatic vfall();
        pix(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
        pix(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        falls++;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        cpu.wr_en = 1'b1; cpu.wr_addr = a; cpu.wr_data = d;
        @(posedge clk);
        #1;
        cpu.wr_en = 1'b0;
    endtask

    initial begin
        // A glyph rows: 2=10 3=38 5=C6 7=FE, 0/15=00. White=FF, red=E0, blue=03.
        vt[0]  = '{10'd3,   10'd2,   1'b1, 1'b1, 8'hFF};
        vt[1]  = '{10'd0,   10'd2,   1'b1, 1'b1, 8'h00};
        vt[2]  = '{10'd0,   10'd5,   1'b1, 1'b0, 8'hFF};
        vt[3]  = '{10'd2,   10'd5,   1'b1, 1'b1, 8'h00};
        vt[4]  = '{10'd6,   10'd7,   1'b1, 1'b1, 8'hFF};
        vt[5]  = '{10'd7,   10'd7,   1'b1, 1'b1, 8'h00};
        vt[6]  = '{10'd4,   10'd0,   1'b1, 1'b1, 8'h00};
        vt[7]  = '{10'd11,  10'd5,   1'b1, 1'b1, 8'h00};
        vt[8]  = '{10'd3,   10'd2,   1'b0, 1'b1, 8'h00};
        vt[9]  = '{10'd635, 10'd466, 1'b1, 1'b1, 8'hE0};
        vt[10] = '{10'd632, 10'd466, 1'b1, 1'b0, 8'h03};
        vt[11] = '{10'd638, 10'd471, 1'b1, 1'b1, 8'hE0};
        vt[12] = '{10'd639, 10'd471, 1'b1, 1'b1, 8'h03};
        vt[13] = '{10'd639, 10'd479, 1'b1, 1'b1, 8'h03};
        vt[14] = '{10'd700, 10'd500, 1'b0, 1'b1, 8'h00};
        vt[15] = '{10'd4,   10'd3,   1'b1, 1'b1, 8'hFF};

        rst = 1'b1; pix_en = 1'b0;
        x_ptr = '0; y_ptr = '0; valid_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        cpu.wr_en = 1'b0; cpu.wr_addr = '0; cpu.wr_data = '0;
        cpu.cursor_addr = '0; cpu.cursor_en = 1'b0;

        // Reset held while pixels tick: pins stay idle.
        cpu_write(12'd0, 16'h3800);
        for (int i = 0; i < 3; i++) begin
            pix(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
            check($sformatf("rst_rgb_%0d", i), rgb, 8'h00);
            check($sformatf("rst_hs_%0d", i), {7'b0, hsync}, 8'h01);
            check($sformatf("rst_vs_%0d", i), {7'b0, vsync}, 8'h01);
        end
        @(negedge clk);
        rst = 1'b0;

        // First visible pixel after release lands on the third tick.
        idle();
        idle();
        pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        check("lat_t1", rgb, 8'h00);
        idle();
        check("lat_t2", rgb, 8'h00);
        idle();
        check("lat_t3", rgb, 8'hFF);
        idle();
        check("lat_t4", rgb, 8'h00);

        // Static text: white A at cell 0, blank cell 1, red-on-blue A at last cell.
        cpu_write(12'd0, 16'h0741);
        cpu_write(12'd1, 16'h0000);
        cpu_write(12'd2399, 16'h0C41);
        cpu_write(12'd2400, 16'h07DB);
        for (int i = 0; i < 16; i++) begin
            pix(vt[i].x, vt[i].y, vt[i].v, vt[i].hs, 1'b1);
            idle();
            idle();
            check($sformatf("vec%0d_rgb", i), rgb, vt[i].rgb);
            check($sformatf("vec%0d_hs", i), {7'b0, hsync}, {7'b0, vt[i].hs});
        end

        // Blink with BLINK_FRAMES=2: phase = (falls/2) mod 2; vsync lag checked each frame.
        cpu_write(12'd0, 16'h4741);
        for (int k = 1; k <= 8; k++) begin
            vfall();
            check($sformatf("vs_lag2_%0d", k), {7'b0, vsync}, 8'h01);
            pix(10'd3, 10'd2, 1'b1, 1'b1, 1'b1);
            check($sformatf("vs_lag3_%0d", k), {7'b0, vsync}, 8'h00);
            idle();
            idle();
            check($sformatf("blink_%0d", k), rgb, (((falls >> 1) & 1) != 0) ? 8'hFF : 8'h00);
        end

        // Cursor at cell 81 (row 1, col 1): underline rows 30..31 only in phase 1.
        cpu_write(12'd81, 16'h0741);
        cpu_write(12'd82, 16'h0141);
        @(negedge clk);
        cpu.cursor_en = 1'b1;
        cpu.cursor_addr = 12'd81;
        render("cur_ph0_y30", 10'd10, 10'd30, 8'h00);
        vfall();
        vfall();
        render("cur_ph1_y30", 10'd10, 10'd30, 8'hFF);
        render("cur_ph1_y29", 10'd10, 10'd29, 8'h00);
        render("cur_ph1_y31", 10'd10, 10'd31, 8'hFF);
        render("cur_other_cell", 10'd18, 10'd30, 8'h00);
        pix(10'd10, 10'd30, 1'b1, 1'b1, 1'b1);
        cpu.cursor_addr = 12'd82;
        pix(10'd18, 10'd30, 1'b1, 1'b1, 1'b1);
        idle();
        check("cur_move_old", rgb, 8'hFF);
        idle();
        check("cur_move_new", rgb, 8'h03);
        render("cur_left_cell", 10'd10, 10'd30, 8'h00);
        cpu.cursor_en = 1'b0;
        render("cur_disabled", 10'd18, 10'd30, 8'h00);

        // Write to the cell being read in the same clk: old data now, new data next pixel.
        cpu_write(12'd0, 16'h0741);
        pix_w(10'd3, 10'd2, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, 16'h0C41);
        pix(10'd3, 10'd2, 1'b1, 1'b1, 1'b1);
        idle();
        check("rw_old", rgb, 8'hFF);
        idle();
        check("rw_new", rgb, 8'hE0);

        // Mid-frame reset: immediate flush, blink restarts at phase 0, buffer kept.
        cpu_write(12'd0, 16'h4741);
        for (int i = 0; i < 3; i++) begin
            pix(10'd3, 10'd2, 1'b1, 1'b0, 1'b1);
        end
        check("pre_rst_rgb", rgb, 8'hFF);
        check("pre_rst_hs", {7'b0, hsync}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_flush_rgb", rgb, 8'h00);
        check("rst_flush_hs", {7'b0, hsync}, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        falls = 0;
        render("rst_phase0", 10'd3, 10'd2, 8'h00);
        render("rst_ram_kept", 10'd11, 10'd18, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_text_render.md
# vga_text_render

Text-mode pixel renderer sitting directly downstream of the 640×480@60 Hz VGA timing generator. It consumes the generator's pixel coordinates, valid flag and syncs, and owns an 80×30 character buffer written by the CPU. It looks up 8×16 glyphs and drives the 8-bit VGA colour pins plus re-aligned syncs. It also provides a hardware blinking cursor and a per-character blink attribute.

## Interface
Parameters:
- COLS, 80, characters per row
- ROWS, 30, character rows
- BLINK_FRAMES, 30, frames per blink half-period

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-rate enable, one clk in four, aligned with the generator's counter advance
- x_ptr  in  10  pixel column from timing generator
- y_ptr  in  10  pixel row from timing generator
- valid_in  in  1  visible-area flag from timing generator
- hsync_in, vsync_in  in  1 each  syncs from timing generator, active low
- wr_en  in  1  CPU write strobe, one clk wide
- wr_addr  in  12  cell index, row*COLS+col
- wr_data  in  16  attribute word: [7:0] char code, [10:8] fg RGB, [13:11] bg RGB, [14] blink, [15] reserved
- cursor_addr  in  12  cursor cell index
- cursor_en  in  1  cursor visible
- hsync, vsync  out  1 each  syncs delayed to match the pixel pipeline
- VGA_R  out  3  red
- VGA_G  out  3  green
- VGA_B  out  2  blue

## Operation
- Text buffer: COLS*ROWS×16 simple dual-port RAM.
  - Writes occur on any clk with wr_en=1, independent of pix_en.
  - A wr_addr ≥ COLS*ROWS is ignored.
  - Power-up content is 0x0000. rst does not clear the buffer.
- Pipeline stages advance only on clk with pix_en=1:
  - S1: cell = (y_ptr>>4)*COLS + (x_ptr>>3), computed as shifts/adds with no multiplier. Synchronous RAM read. Register x[2:0], y[3:0], valid, syncs, and cur_hit = cursor_en & (cell==cursor_addr).
  - S2: font ROM read at {char, y[3:0]}. Register attributes and the delayed sidebands.
  - S3: pixel bit = glyph[7 − x[2:0]]; on = bit & ~(blink & ~phase); if cur_hit & phase & y[3:0]≥14, on=1. Colour c = on ? fg : bg. VGA_R={3{c[2]}}, VGA_G={3{c[1]}}, VGA_B={2{c[0]}}. All colour outputs are 0 when the delayed valid=0.
- Blink timer:
  - The frame counter increments when S1 samples a vsync_in falling edge, i.e. previous sample 1, current 0.
  - At BLINK_FRAMES−1 it wraps to 0 and toggles phase.
- Same-address read/write in one clk: the read returns old data. The new data is visible on the next pixel.

## Timing
- Latency: RGB, hsync and vsync lag their inputs by exactly 3 pix_en ticks. Sync-to-pixel alignment is therefore preserved.
- Outputs are registered and change only on clk edges where pix_en=1.
- Reset values: VGA_R/G/B=0, hsync=1, vsync=1, all pipeline valid bits=0, frame counter=0, phase=0.
  - The first real pixel appears 3 ticks after the first valid_in following reset release.
- Reset mid-frame: the pipeline flushes immediately. Blink restarts from phase 0. Text RAM contents are unaffected.
- x_ptr/y_ptr outside the visible area: the address is still computed, but the result is masked by valid. Out-of-range cell indices must not write or wrap into the buffer.

## Structure
- Package vga_pkg holds:
  - COLS, ROWS, CELL_W=8, CELL_H=16
  - attribute field positions
  - the RGB332 expansion function
- Sub-module font_rom: 4096×8 synchronous-read ROM, addressed {char, row}, initialised from a hex file. The CP437 subset is the minimum content.
- The text RAM is inferred inline.

## Test plan
- Reset with pix_en toggling → RGB=0, hsync=vsync=1. After release, the first output pixel appears exactly 3 pix_en ticks after valid_in rises.
- Write 0x0741 ('A', fg=7, bg=0) to cell 0 → pixels (0..7, 0..15) match the 'A' glyph rows: white on set bits, black elsewhere. Cell 1 (0x0000) renders all black.
- Write cell 2399 (row 29, col 79) with fg=4, bg=1 → pixels x 632..639, y 464..479 show red/blue per glyph. A write to 2400 leaves the display unchanged.
- Blink attribute 0x4741 with BLINK_FRAMES=2 → the glyph is visible for 2 frames, then shows bg for 2 frames, repeating. This holds across 8 vsync falling edges.
- cursor_en=1, cursor_addr=81 → cell (row 1, col 1), pixel rows 30..31, show fg during phase 1 and normal glyph during phase 0. Moving cursor_addr takes effect on the next pixel of that cell.
- Write to the cell currently being scanned, same clk as the S1 read → the current pixel shows old data and the next pixel shows new data. Sync edges stay 3 ticks delayed throughout.
